mem_store_buffer: RTL
=====================

// Module: mem_store_buffer
// PURPOSE
//  Word-granular store buffer between the MEM pipeline stage and DataMemory.
//  Decouples stores from the single memory address port: stores enqueue, drain
//  to DataMemory one per idle cycle; loads own the port and forward from the
//  youngest matching buffered store. Drives DataMemory WE/A/WD, consumes its RD.
// PARAMETERS
//  DEPTH      4    buffer entries (power of 2, >=2)
//  AW         32   address width (byte address; word index = addr[AW-1:2])
//  DW         32   data width
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-high; clears buffer
//  st_valid   in   1    MEM stage issues a word store this cycle
//  st_addr    in   AW   store byte address (bits [1:0] ignored)
//  st_data    in   DW   store data
//  ld_valid   in   1    MEM stage issues a word load this cycle
//  ld_addr    in   AW   load byte address (bits [1:0] ignored)
//  ld_data    out  DW   load result, combinational, same cycle
//  stall      out  1    store cannot be accepted; pipeline must hold MEM
//  empty      out  1    no pending stores (used for halt/fence)
//  mem_we     out  1    to DataMemory WE
//  mem_addr   out  AW   to DataMemory A
//  mem_wd     out  DW   to DataMemory WD
//  mem_rd     in   DW   from DataMemory RD
// BEHAVIOUR
//  - Circular FIFO: head/tail ptrs (log2 DEPTH bits, wrap), count 0..DEPTH.
//  - Reset (async): count=0, ptrs=0, all valid bits cleared; outputs: mem_we=0,
//    stall=0, empty=1, mem_addr=0, mem_wd=0; ld_data=mem_rd.
//  - Reset mid-drain: buffered stores discarded, none written afterwards.
//  - Port arbitration per cycle:
//      ld_valid=1        -> mem_addr=ld_addr, mem_we=0, no drain.
//      ld_valid=0,count>0-> drain: mem_addr/mem_wd=head entry, mem_we=1;
//                           head advances at clk edge (DataMemory writes same edge).
//      otherwise         -> mem_we=0, mem_addr=0, mem_wd=0.
//  - Enqueue at clk edge when st_valid && !stall; writes tail, tail advances.
//  - stall = st_valid && (count==DEPTH) && !drain; full+drain same cycle
//    accepts the store (count unchanged). stall is combinational.
//  - count update: +1 enqueue only, -1 drain only, unchanged for both/neither.
//  - Load forwarding: compare ld_addr[AW-1:2] against all valid entries;
//    ld_data = data of youngest match (closest to tail), else mem_rd.
//    Latency 0 (combinational), matches DataMemory async read.
//  - Store and load in same cycle: both legal; load does NOT see the incoming
//    store (it is enqueued at the edge); load does see all older entries.
//  - Multiple entries same word: all kept, drained in order; memory ends with
//    youngest value.
//  - empty = (count==0). No store is ever lost or reordered.
// STRUCTURE
//  - Shared package (mem_pkg): WORD_IDX_MSB/LSB constants, store_entry_t
//    {valid, word_addr, data}; reused by DataMemory-side checkers.
//  - One sub-module: sb_fwd_match -- priority matcher returning youngest hit
//    index + hit flag, given entries, head, count, lookup word address.
//  - Top holds FIFO regs, pointers, arbitration mux.
// TESTING
//  1 reset; st 0x10<=0xAAAA5555, no loads -> next cycle mem_we=1,
//    mem_addr=0x10, mem_wd=0xAAAA5555; following cycle empty=1.
//  2 ld_valid held high, 4 stores -> count=4, mem_we=0; 5th store -> stall=1;
//    drop ld_valid -> drain starts, 5th store accepted same cycle, stall=0.
//  3 st 0x20<=1, st 0x20<=2, ld 0x20 while both buffered -> ld_data=2;
//    ld 0x24 -> ld_data=mem_rd; after drain, mem[0x20]=2.
//  4 st 0x30<=7 with ld 0x30 same cycle (mem holds 0) -> ld_data=0; next-cycle
//    ld 0x30 -> 7.
//  5 fill 3 entries, assert reset mid-drain -> mem_we=0 immediately, empty=1;
//    memory holds only stores drained before reset.
//  6 wrap: 10 stores to distinct words interleaved with loads -> head/tail wrap,
//    final memory matches reference model, order preserved.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared store-buffer definitions: word-index slice and buffered store entry layout.
package mem_pkg;

   // Byte address bits that form the word index (word-granular accesses).
   localparam int unsigned WORD_IDX_MSB = 31;
   localparam int unsigned WORD_IDX_LSB = 2;
   localparam int unsigned ENTRY_DW     = 32;

   // One buffered store, also the layout used by DataMemory-side checkers.
   typedef struct packed {
      logic                                valid;
      logic [WORD_IDX_MSB-WORD_IDX_LSB:0]  word_addr;
      logic [ENTRY_DW-1:0]                 data;
   } store_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Priority matcher: finds the youngest valid buffered store whose word address
// equals the lookup address. Entries are scanned oldest-to-youngest from head,
// so the last hit found is the youngest.
module sb_fwd_match #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WAW   = 30
) (
   input  logic [DEPTH-1:0]                              valid,
   input  logic [WAW-1:0]                                word_addr [DEPTH],
   input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  head,
   input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1):0]    count,
   input  logic [WAW-1:0]                                lookup,
   output logic                                          hit,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  hit_idx
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] idx;

   // Age-ordered scan; a later (younger) hit overrides an earlier one.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && valid[idx] && (word_addr[idx] == lookup)) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end
   end

endmodule

// File: rtl/mem_store_buffer.sv
// Word-granular store buffer between MEM and DataMemory. Stores queue in a
// circular FIFO and drain one per cycle when no load owns the memory port;
// loads forward from the youngest matching buffered store.
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   output logic          stall,
   output logic          empty,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned WAW = AW - WORD_IDX_LSB;

   logic [DEPTH-1:0] ent_valid;
   logic [WAW-1:0]   ent_waddr [DEPTH];
   logic [DW-1:0]    ent_data  [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;

   logic             full;
   logic             drain;
   logic             enq;
   logic             hit;
   logic [PW-1:0]    hit_idx;
   logic             unused_st_lsbs;

   // Byte offset within the word is irrelevant for word stores.
   assign unused_st_lsbs = ^st_addr[WORD_IDX_LSB-1:0];

   assign full  = (count == CW'(DEPTH));
   // A load owns the port; otherwise the oldest entry drains.
   assign drain = !ld_valid && (count != '0);
   // A full buffer still accepts a store in a cycle that frees an entry.
   assign stall = st_valid && full && !drain;
   assign enq   = st_valid && !stall;
   assign empty = (count == '0);

   // Memory port arbitration: load address, head-entry write, or idle zeros.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (ld_valid) begin
         mem_addr = ld_addr;
      end else if (drain) begin
         mem_we   = 1'b1;
         mem_addr = {ent_waddr[head], {WORD_IDX_LSB{1'b0}}};
         mem_wd   = ent_data[head];
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .WAW   (WAW)
   ) u_fwd_match (
      .valid     (ent_valid),
      .word_addr (ent_waddr),
      .head      (head),
      .count     (count),
      .lookup    (ld_addr[AW-1:WORD_IDX_LSB]),
      .hit       (hit),
      .hit_idx   (hit_idx)
   );

   // Load result: youngest buffered match, else DataMemory read data.
   always_comb begin
      ld_data = mem_rd;
      if (hit) begin
         ld_data = ent_data[hit_idx];
      end
   end

   // Entry storage and pointers; enqueue is applied after drain so a full
   // buffer draining and enqueueing the same slot leaves it valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_valid <= '0;
         head      <= '0;
         tail      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_waddr[i] <= '0;
            ent_data[i]  <= '0;
         end
      end else begin
         if (drain) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PW'(1);
         end
         if (enq) begin
            ent_valid[tail] <= 1'b1;
            ent_waddr[tail] <= st_addr[AW-1:WORD_IDX_LSB];
            ent_data[tail]  <= st_data;
            tail            <= tail + PW'(1);
         end
      end
   end

   // Occupancy: +1 enqueue only, -1 drain only, else unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({enq, drain})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
